// File: rtl/ram_scan_pkg.sv
// Shared types and constants for the lab-RAM read scanner.
// The expected-word helper is used by the optional checker (RAM_SCAN_CHECK_EN).
package ram_scan_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DONE
  } state_t;

  // Test pattern held in the RAM: (addr + 1) truncated to data_w bits.
  function automatic logic [31:0] expected_word(input logic [31:0] addr, input int data_w);
    logic [31:0] mask;
    mask = (32'd1 << data_w) - 32'd1;
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/ram_scan_checker.sv
// Compares each captured word against the (addr+1) pattern.
// Keeps a sticky error flag and the address of the first mismatch.
module ram_scan_checker
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  logic mismatch;

  assign mismatch = (32'(cap_data) != expected_word(32'(cap_addr), DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (clear) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (cap_en && mismatch && !err) begin
      // Only the first mismatch of a scan is recorded.
      err      <= 1'b1;
      err_addr <= cap_addr;
    end
  end

endmodule

// File: rtl/ram_scanner.sv
// Read-side scanner: walks every RAM address, waits RD_LAT edges, streams (addr,data).
// Optional pattern checker is built when RAM_SCAN_CHECK_EN is defined.
module ram_scanner
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
`ifdef RAM_SCAN_CHECK_EN
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
`endif
  output state_t            state
);

  // Stream handshake: a word transfers on a rising edge where rd_valid && rd_ready;
  // rd_data/rd_addr stay frozen while rd_valid=1 and rd_ready=0, rd_ready is ignored otherwise.

  localparam logic [1:0] LAT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic [1:0] lat_cnt;
  logic       capture;

  // RAM data is sampled on the edge that ends ISSUE (zero latency) or the last WAIT cycle.
  assign capture = ((state == ISSUE) && (RD_LAT == 0)) ||
                   ((state == WAIT) && (lat_cnt == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_address <= '0;
      rd_data     <= '0;
      rd_addr     <= '0;
      rd_valid    <= 1'b0;
      lat_cnt     <= 2'd0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        rd_data  <= ram_dout;
        rd_addr  <= ram_address;
        rd_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            ram_address <= '0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (RD_LAT == 0) begin
            state <= HOLD;
          end else begin
            lat_cnt <= LAT_LAST;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= HOLD;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (ram_address == ADDR_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ram_address <= ram_address + ADDR_W'(1);
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_SCAN_CHECK_EN
  logic accept;

  assign accept = (state == IDLE) && start;

  ram_scan_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .cap_en   (capture),
    .cap_addr (ram_address),
    .cap_data (ram_dout),
    .err      (err),
    .err_addr (err_addr)
  );
`endif

endmodule

// File: tb/tb_ram_scanner.sv
// Directed bench for ram_scanner with a 1-cycle-latency 4x3 RAM model.
// Define RAM_SCAN_CHECK_EN to also exercise err/err_addr.
module tb_ram_scanner;
  import ram_scan_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] ram_address;
  logic [2:0] ram_dout;
  logic [2:0] rd_data;
  logic [1:0] rd_addr;
  logic       rd_valid;
  logic       rd_ready;
  state_t     state;
`ifdef RAM_SCAN_CHECK_EN
  logic       err;
  logic [1:0] err_addr;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int word_cnt = 0;
  int done_cnt = 0;
  logic [4:0] exp_q[$];
  logic [2:0] mem[4];
  logic [2:0] ram_q;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_scanner #(
    .ADDR_W(2),
    .DATA_W(3),
    .RD_LAT(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_dout    (ram_dout),
    .rd_data     (rd_data),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
`ifdef RAM_SCAN_CHECK_EN
    .err         (err),
    .err_addr    (err_addr),
`endif
    .state       (state)
  );

  // RAM model: address sampled on an edge, data valid after that edge.
  always @(posedge clk) ram_q <= mem[ram_address];
  assign ram_dout = ram_q;

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_scan();
    exp_q.push_back({2'd0, 3'b001});
    exp_q.push_back({2'd1, 3'b010});
    exp_q.push_back({2'd2, 3'b011});
    exp_q.push_back({2'd3, 3'b100});
  endtask

  task automatic wait_state(input string tag, input state_t s, input logic [1:0] a);
    int g = 0;
    while (!((state == s) && (ram_address == a)) && (g < 50)) begin
      step();
      g++;
    end
    check(tag, 32'((state == s) && (ram_address == a)), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && (n < 100));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flags"}, {29'd0, busy, done, rd_valid}, 32'd0);
    check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
`ifdef RAM_SCAN_CHECK_EN
    check({tag, "_err"}, {29'd0, err, err_addr}, 32'd0);
`endif
  endtask

  task automatic check_scan_end(input string tag);
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    step();
    check({tag, "_done_low"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_idle"}, 32'(state), 32'(IDLE));
    check({tag, "_words"}, 32'(word_cnt), 32'd4);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done) done_cnt = done_cnt + 1;
    if (rst_n && rd_valid && rd_ready) begin
      word_cnt = word_cnt + 1;
      if (exp_q.size() != 0) check("stream_word", 32'({rd_addr, rd_data}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    mem[0] = 3'b001;
    mem[1] = 3'b010;
    mem[2] = 3'b011;
    mem[3] = 3'b100;
    rst_n    = 1'b0;
    start    = 1'b0;
    rd_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset release with no start: everything stays at reset values.
    for (int i = 0; i < 10; i++) begin
      check_idle("reset_idle");
      step();
    end

    // Full scan with rd_ready held high, with latency checks on word 0.
    word_cnt = 0;
    done_cnt = 0;
    push_scan();
    pulse_start();
    check("a_busy_e0", 32'(busy), 32'd1);
    check("a_addr_e0", 32'(ram_address), 32'd0);
    check("a_state_e0", 32'(state), 32'(ISSUE));
    check("a_valid_e0", 32'(rd_valid), 32'd0);
    step();
    check("a_state_e1", 32'(state), 32'(WAIT));
    check("a_valid_e1", 32'(rd_valid), 32'd0);
    step();
    check("a_valid_e2", 32'(rd_valid), 32'd1);
    check("a_word0", 32'({rd_addr, rd_data}), 32'({2'd0, 3'b001}));
    wait_done(n);
    check("a_done_latency", 32'(n + 2), 32'd12);
`ifdef RAM_SCAN_CHECK_EN
    check("a_err", 32'(err), 32'd0);
`endif
    check_scan_end("a");

    // Backpressure of 5 cycles on word 1; start is accepted the cycle after done.
    word_cnt = 0;
    done_cnt = 0;
    push_scan();
    pulse_start();
    check("b_accept", 32'(state), 32'(ISSUE));
    wait_state("b_reach_issue1", ISSUE, 2'd1);
    rd_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("b_hold_valid", 32'(rd_valid), 32'd1);
      check("b_hold_word", 32'({rd_addr, rd_data}), 32'({2'd1, 3'b010}));
      step();
    end
    check("b_hold_state", 32'(state), 32'(HOLD));
    check("b_words_during_stall", 32'(word_cnt), 32'd1);
    rd_ready = 1'b1;
    wait_done(n);
    check_scan_end("b");

    // Second start while busy is ignored.
    step();
    word_cnt = 0;
    done_cnt = 0;
    push_scan();
    pulse_start();
    repeat (3) step();
    pulse_start();
    wait_done(n);
    check_scan_end("c");
    repeat (3) step();
    check("c_no_restart", 32'(state), 32'(IDLE));
    check("c_done_cnt_after", 32'(done_cnt), 32'd1);

`ifdef RAM_SCAN_CHECK_EN
    // Corrupted word at address 2 raises err; next start clears it.
    mem[2] = 3'b111;
    word_cnt = 0;
    done_cnt = 0;
    exp_q.push_back({2'd0, 3'b001});
    exp_q.push_back({2'd1, 3'b010});
    exp_q.push_back({2'd2, 3'b111});
    exp_q.push_back({2'd3, 3'b100});
    pulse_start();
    wait_state("e_reach_hold1", HOLD, 2'd1);
    check("e_err_before", 32'(err), 32'd0);
    wait_state("e_reach_hold2", HOLD, 2'd2);
    check("e_err_set", {29'd0, err, err_addr}, {29'd0, 1'b1, 2'd2});
    wait_done(n);
    check("e_err_at_done", {29'd0, err, err_addr}, {29'd0, 1'b1, 2'd2});
    check_scan_end("e");
    mem[2] = 3'b011;
    word_cnt = 0;
    done_cnt = 0;
    push_scan();
    pulse_start();
    check("e_err_cleared", {29'd0, err, err_addr}, 32'd0);
    wait_done(n);
    check("e_err_clean_scan", 32'(err), 32'd0);
    check_scan_end("e2");
`endif

    // Reset pulse during word 2's WAIT, then a clean full scan.
    step();
    word_cnt = 0;
    done_cnt = 0;
    exp_q.push_back({2'd0, 3'b001});
    exp_q.push_back({2'd1, 3'b010});
    pulse_start();
    wait_state("r_reach_wait2", WAIT, 2'd2);
    rst_n = 1'b0;
    #2;
    check_idle("r_async");
    step();
    rst_n = 1'b1;
    step();
    check_idle("r_after");
    check("r_words", 32'(word_cnt), 32'd2);
    check("r_q_empty", 32'(exp_q.size()), 32'd0);
    word_cnt = 0;
    done_cnt = 0;
    push_scan();
    pulse_start();
    check("r_restart_addr", 32'(ram_address), 32'd0);
    wait_done(n);
    check("r_done_latency", 32'(n), 32'd12);
    check_scan_end("r");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
